// File: rtl/kfmmc_block_reader.sv
// kfmmc_block_reader
//   Read sequencer between a block consumer and the KFMMC_Drive host-side register strobes.
//   For each block it writes the 32-bit block address (four byte strobes) and the read
//   command, then forwards every drive byte over a valid/ready stream. Downstream logic
//   sees only the byte stream and never touches the drive strobes.
//
// Ports
//   clock, reset                  single clock, synchronous active-high reset
//   start, start_block,           sequence request (sampled only while idle)
//   block_count
//   busy, done, error,            sequence status; error/error_code are sticky until the
//   error_code                    next accepted start (1 iface, 2 crc, 3 timeout/length)
//   out_data, out_valid,          byte stream; out_last marks byte 511 of a block,
//   out_ready, out_last,          out_block is the 0-based block index in the sequence
//   out_block
//   internal_data_bus,            drive register bus and one-cycle write strobes
//   write_block_address_1..4,
//   write_access_command
//   read_data                     one-cycle "byte consumed" pulse to the drive
//   read_data_byte, drive_busy,   drive status and data
//   read_interface_error,
//   read_crc_error,
//   block_read_interrupt,
//   read_completion_interrupt
//
// Build option
//   KFMMC_READER_LEN_CHECK_EN : when defined, a block that completes without drive error
//   but with a byte count other than 512 ends the sequence with error code 3.

module kfmmc_block_reader #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h00FFFFFF,
    parameter logic [7:0]  READ_COMMAND   = 8'h80
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] start_block,
    input  logic [7:0]  block_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [7:0]  out_block,
    output logic [7:0]  internal_data_bus,
    output logic        write_block_address_1,
    output logic        write_block_address_2,
    output logic        write_block_address_3,
    output logic        write_block_address_4,
    output logic        write_access_command,
    output logic        read_data,
    input  logic [7:0]  read_data_byte,
    input  logic        drive_busy,
    input  logic        read_interface_error,
    input  logic        read_crc_error,
    input  logic        block_read_interrupt,
    input  logic        read_completion_interrupt
);

    typedef enum logic [3:0] {
        StIdle, StWaitReady, StAddr1, StAddr2, StAddr3, StAddr4,
        StCmd, StWaitData, StHold, StAck, StNext
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [7:0]  block_q, block_d;
    logic [9:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [1:0]  code_q, code_d;

    logic        fail;
    logic [1:0]  fail_code;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            block_q     <= '0;
            byte_cnt_q  <= '0;
            tmo_q       <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            code_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            block_q     <= block_d;
            byte_cnt_q  <= byte_cnt_d;
            tmo_q       <= tmo_d;
            data_q      <= data_d;
            done_q      <= done_d;
            error_q     <= error_d;
            code_q      <= code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        block_d     = block_q;
        byte_cnt_d  = byte_cnt_q;
        data_d      = data_q;
        done_d      = 1'b0;
        error_d     = error_q;
        code_d      = code_q;
        // Timeout counter only survives while staying in a wait state.
        tmo_d       = '0;
        fail        = 1'b0;
        fail_code   = 2'd0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    error_d     = 1'b0;
                    code_d      = 2'd0;
                    addr_d      = start_block;
                    remaining_d = block_count;
                    block_d     = '0;
                    if (block_count == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StWaitReady;
                    end
                end
            end
            StWaitReady: begin
                if (!drive_busy) begin
                    state_d = StAddr1;
                end else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                    fail      = 1'b1;
                    fail_code = 2'd3;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StAddr1: state_d = StAddr2;
            StAddr2: state_d = StAddr3;
            StAddr3: state_d = StAddr4;
            StAddr4: state_d = StCmd;
            StCmd: begin
                byte_cnt_d = '0;
                state_d    = StWaitData;
            end
            StWaitData: begin
                // Completion takes priority over a coincident byte interrupt.
                if (read_completion_interrupt) begin
                    if (read_interface_error) begin
                        fail      = 1'b1;
                        fail_code = 2'd1;
                    end else if (read_crc_error) begin
                        fail      = 1'b1;
                        fail_code = 2'd2;
`ifdef KFMMC_READER_LEN_CHECK_EN
                    end else if (byte_cnt_q != 10'd512) begin
                        fail      = 1'b1;
                        fail_code = 2'd3;
`endif
                    end else begin
                        state_d = StNext;
                    end
                end else if (block_read_interrupt) begin
                    data_d  = read_data_byte;
                    state_d = StHold;
                end else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                    fail      = 1'b1;
                    fail_code = 2'd3;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                byte_cnt_d = byte_cnt_q + 10'd1;
                state_d    = StWaitData;
            end
            StNext: begin
                addr_d      = addr_q + 32'd1;
                block_d     = block_q + 8'd1;
                remaining_d = remaining_q - 8'd1;
                if (remaining_q == 8'd1) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StWaitReady;
                end
            end
            default: state_d = StIdle;
        endcase

        if (fail) begin
            done_d  = 1'b1;
            error_d = 1'b1;
            code_d  = fail_code;
            state_d = StIdle;
        end
    end

    always_comb begin
        busy                  = (state_q != StIdle);
        out_valid             = (state_q == StHold);
        out_last              = (state_q == StHold) && (byte_cnt_q == 10'd511);
        write_block_address_1 = (state_q == StAddr1);
        write_block_address_2 = (state_q == StAddr2);
        write_block_address_3 = (state_q == StAddr3);
        write_block_address_4 = (state_q == StAddr4);
        write_access_command  = (state_q == StCmd);
        read_data             = (state_q == StAck);
        internal_data_bus     = 8'h00;
        case (state_q)
            StAddr1: internal_data_bus = addr_q[7:0];
            StAddr2: internal_data_bus = addr_q[15:8];
            StAddr3: internal_data_bus = addr_q[23:16];
            StAddr4: internal_data_bus = addr_q[31:24];
            StCmd:   internal_data_bus = READ_COMMAND;
            default: internal_data_bus = 8'h00;
        endcase
    end

    assign out_data   = data_q;
    assign out_block  = block_q;
    assign done       = done_q;
    assign error      = error_q;
    assign error_code = code_q;

endmodule

// File: tb/tb_kfmmc_block_reader.sv
module tb_kfmmc_block_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] start_block;
    logic [7:0]  block_count;
    logic        busy, done, error;
    logic [1:0]  error_code;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [7:0]  out_block;
    logic [7:0]  internal_data_bus;
    logic        write_block_address_1, write_block_address_2;
    logic        write_block_address_3, write_block_address_4;
    logic        write_access_command;
    logic        read_data;
    logic [7:0]  read_data_byte;
    logic        drive_busy;
    logic        read_interface_error, read_crc_error;
    logic        block_read_interrupt, read_completion_interrupt;

`ifdef KFMMC_READER_LEN_CHECK_EN
    localparam logic [1:0] LenCode = 2'd3;
`else
    localparam logic [1:0] LenCode = 2'd0;
`endif

    kfmmc_block_reader #(
        .TIMEOUT_CYCLES(32'd100),
        .READ_COMMAND  (8'h80)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .start                    (start),
        .start_block              (start_block),
        .block_count              (block_count),
        .busy                     (busy),
        .done                     (done),
        .error                    (error),
        .error_code               (error_code),
        .out_data                 (out_data),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .out_last                 (out_last),
        .out_block                (out_block),
        .internal_data_bus        (internal_data_bus),
        .write_block_address_1    (write_block_address_1),
        .write_block_address_2    (write_block_address_2),
        .write_block_address_3    (write_block_address_3),
        .write_block_address_4    (write_block_address_4),
        .write_access_command     (write_access_command),
        .read_data                (read_data),
        .read_data_byte           (read_data_byte),
        .drive_busy               (drive_busy),
        .read_interface_error     (read_interface_error),
        .read_crc_error           (read_crc_error),
        .block_read_interrupt     (block_read_interrupt),
        .read_completion_interrupt(read_completion_interrupt)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- drive model (per-cycle, at posedge+1) ----------------
    int dm_st = 0, dm_cnt = 0, dm_byte = 0;
    int dm_len = 512, dm_bp = 0, dm_wcnt = 0;
    bit dm_crc = 0, dm_iface = 0, dm_silent = 0;

    initial begin
        block_read_interrupt      = 1'b0;
        read_completion_interrupt = 1'b0;
        read_interface_error      = 1'b0;
        read_crc_error            = 1'b0;
        read_data_byte            = 8'h00;
        out_ready                 = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            block_read_interrupt      = 1'b0;
            read_completion_interrupt = 1'b0;
            read_interface_error      = 1'b0;
            read_crc_error            = 1'b0;
            if (reset) begin
                dm_st = 0;
            end else begin
                case (dm_st)
                    0: if (write_access_command) begin
                        dm_byte = 0;
                        dm_cnt  = 0;
                        dm_st   = dm_silent ? 0 : 1;
                    end
                    1: begin
                        dm_cnt++;
                        if (dm_cnt >= 2) begin
                            if (dm_byte == dm_len) begin
                                read_completion_interrupt = 1'b1;
                                read_interface_error      = dm_iface;
                                read_crc_error            = dm_crc;
                                dm_st = 0;
                            end else begin
                                block_read_interrupt = 1'b1;
                                read_data_byte       = dm_byte[7:0];
                                dm_st = 2;
                            end
                        end
                    end
                    2: if (read_data) begin
                        dm_byte++;
                        dm_cnt = 0;
                        dm_st  = 1;
                    end
                    default: dm_st = 0;
                endcase
            end
            // Consumer: hold ready low for dm_bp cycles of each valid byte.
            if (out_valid) begin
                out_ready = (dm_wcnt >= dm_bp);
                dm_wcnt++;
            end else begin
                dm_wcnt   = 0;
                out_ready = (dm_bp == 0);
            end
        end
    end

    // ---------------- monitor (negedge) ----------------
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    wire mon_hs = out_valid && out_ready;
    int hs_cnt = 0, last_cnt = 0, cmd_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int viol = 0, inblk = 0, last_cmd_cyc = 0, last_done_cyc = 0;
    logic [7:0] mblk = 8'h00;
    logic prev_valid = 0, prev_hs = 0, prev_busy = 0, prev_last = 0;
    logic [7:0] prev_data = 0, prev_block = 0;
    logic [15:0] strobe_q[$];
    int a1_q[$];

    always @(negedge clock) begin
        if (reset) begin
            prev_valid <= 1'b0;
            prev_hs    <= 1'b0;
            prev_busy  <= 1'b0;
        end else begin
            if ($countones({write_block_address_1, write_block_address_2, write_block_address_3,
                            write_block_address_4, write_access_command, read_data}) > 1)
                viol <= viol + 1;
            if (write_block_address_1) begin
                strobe_q.push_back({8'd1, internal_data_bus});
                a1_q.push_back(cyc);
            end
            if (write_block_address_2) strobe_q.push_back({8'd2, internal_data_bus});
            if (write_block_address_3) strobe_q.push_back({8'd3, internal_data_bus});
            if (write_block_address_4) strobe_q.push_back({8'd4, internal_data_bus});
            if (busy && !prev_busy) mblk <= 8'hFF;
            else if (write_access_command) mblk <= mblk + 8'd1;
            if (write_access_command) begin
                strobe_q.push_back({8'd5, internal_data_bus});
                cmd_cnt      <= cmd_cnt + 1;
                inblk        <= 0;
                last_cmd_cyc <= cyc;
            end else if (mon_hs) begin
                inblk <= inblk + 1;
            end
            if (out_valid && (out_data != inblk[7:0] || out_block != mblk ||
                              out_last != (inblk == 511)))
                viol <= viol + 1;
            if (prev_valid && !prev_hs && (!out_valid || out_data != prev_data ||
                                           out_last != prev_last || out_block != prev_block))
                viol <= viol + 1;
            if (read_data) begin
                rd_cnt <= rd_cnt + 1;
                if (!prev_hs) viol <= viol + 1;
            end
            if (mon_hs) begin
                hs_cnt <= hs_cnt + 1;
                if (out_last) last_cnt <= last_cnt + 1;
            end
            if (done) begin
                done_cnt      <= done_cnt + 1;
                last_done_cyc <= cyc;
                if (busy) viol <= viol + 1;
            end
            prev_valid <= out_valid;
            prev_hs    <= mon_hs;
            prev_busy  <= busy;
            prev_last  <= out_last;
            prev_data  <= out_data;
            prev_block <= out_block;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] sb;
        logic [7:0]  cnt;
        int          len;
        int          bp;
        bit          crc;
        bit          iface;
        bit          silent;
        bit          poke;
        int          dbusy;
        logic [1:0]  code;
        int          hs;
        int          lasts;
        int          cmds;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [36:0] outs();
        return {busy, done, error, error_code, out_data, out_valid, out_last, out_block,
                internal_data_bus, write_block_address_1, write_block_address_2,
                write_block_address_3, write_block_address_4, write_access_command, read_data};
    endfunction

    task automatic run_vec(input int i);
        vec_t v;
        int b_hs, b_last, b_cmd, b_rd, b_done, b_sq, b_a1, b_viol, s_cyc, nsq;
        bit got;
        logic [31:0] a;
        logic [15:0] exp_s[5];
        v      = tbl[i];
        dm_len = v.len; dm_bp = v.bp; dm_crc = v.crc; dm_iface = v.iface; dm_silent = v.silent;
        b_hs = hs_cnt; b_last = last_cnt; b_cmd = cmd_cnt; b_rd = rd_cnt; b_done = done_cnt;
        b_sq = strobe_q.size(); b_a1 = a1_q.size(); b_viol = viol;
        @(posedge clock); #1;
        start = 1'b1; start_block = v.sb; block_count = v.cnt; drive_busy = (v.dbusy > 0);
        s_cyc = cyc;
        got = 0;
        for (int n = 0; n < 12000; n++) begin
            @(posedge clock); #1;
            start = v.poke && (n == 50);
            if (start) begin
                start_block = 32'h999;
                block_count = 8'd5;
            end
            drive_busy = (n < v.dbusy);
            if (n == 0) check($sformatf("v%0d error_cleared", i), error, 1'b0);
            if (done_cnt != b_done) begin
                got = 1;
                break;
            end
        end
        start = 1'b0;
        check($sformatf("v%0d done_seen", i), got, 1'b1);
        check($sformatf("v%0d error", i), error, (v.code != 2'd0));
        check($sformatf("v%0d error_code", i), error_code, v.code);
        check($sformatf("v%0d busy_after", i), busy, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        check($sformatf("v%0d done_pulses", i), done_cnt - b_done, 1);
        check($sformatf("v%0d handshakes", i), hs_cnt - b_hs, v.hs);
        check($sformatf("v%0d read_data", i), rd_cnt - b_rd, v.hs);
        check($sformatf("v%0d lasts", i), last_cnt - b_last, v.lasts);
        check($sformatf("v%0d cmds", i), cmd_cnt - b_cmd, v.cmds);
        check($sformatf("v%0d protocol", i), viol - b_viol, 0);
        nsq = strobe_q.size() - b_sq;
        check($sformatf("v%0d strobe_count", i), nsq, 5 * v.cmds);
        for (int k = 0; k < v.cmds; k++) begin
            a = v.sb + k;
            exp_s[0] = {8'd1, a[7:0]};
            exp_s[1] = {8'd2, a[15:8]};
            exp_s[2] = {8'd3, a[23:16]};
            exp_s[3] = {8'd4, a[31:24]};
            exp_s[4] = {8'd5, 8'h80};
            for (int j = 0; j < 5; j++)
                if (5 * k + j < nsq)
                    check($sformatf("v%0d strobe%0d", i, 5 * k + j),
                          strobe_q[b_sq + 5 * k + j], exp_s[j]);
        end
        if (v.cnt != 0) begin
            if (a1_q.size() > b_a1) check($sformatf("v%0d addr_latency", i),
                                          a1_q[b_a1] - s_cyc, v.dbusy + 2);
            else check($sformatf("v%0d addr_seen", i), a1_q.size(), b_a1 + 1);
        end
        if (v.lat != 0) check($sformatf("v%0d timeout_latency", i),
                              last_done_cyc - last_cmd_cyc, v.lat);
    endtask

    initial begin
        int b_done, b_hs;
        bit got;
        //        sb            cnt  len  bp crc ifc sil poke dbusy code    hs    last cmd lat
        tbl[0] = '{32'h00000010, 8'd1, 512, 0, 0,  0,  0,  0,   0,  2'd0,   512,  1,   1,  0};
        tbl[1] = '{32'h00000020, 8'd1, 512, 5, 0,  0,  0,  1,   3,  2'd0,   512,  1,   1,  0};
        tbl[2] = '{32'hFFFFFFFF, 8'd3, 512, 0, 0,  0,  0,  0,  10,  2'd0,  1536,  3,   3,  0};
        tbl[3] = '{32'h00000005, 8'd2, 512, 0, 1,  0,  0,  0,   0,  2'd2,   512,  1,   1,  0};
        tbl[4] = '{32'h00000007, 8'd1, 512, 0, 1,  1,  0,  0,   0,  2'd1,   512,  1,   1,  0};
        tbl[5] = '{32'h00000009, 8'd1, 512, 0, 0,  0,  1,  0,   0,  2'd3,     0,  0,   1, 101};
        tbl[6] = '{32'h00000030, 8'd1, 300, 0, 0,  0,  0,  0,   0,  LenCode, 300, 0,   1,  0};
        tbl[7] = '{32'h00000040, 8'd0, 512, 0, 0,  0,  0,  0,   0,  2'd0,     0,  0,   0,  0};
        tbl[8] = '{32'h00000050, 8'd1, 600, 2, 0,  0,  0,  0,   0,  LenCode, 600, 1,   1,  0};

        reset = 1'b1; start = 1'b0; start_block = '0; block_count = '0; drive_busy = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", outs(), 37'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i);

        // Zero-count request: done exactly one cycle after start, never busy.
        @(posedge clock); #1;
        start = 1'b1; start_block = 32'h1234; block_count = 8'd0;
        check("cnt0 done_early", done, 1'b0);
        @(posedge clock); #1;
        start = 1'b0;
        check("cnt0 done", done, 1'b1);
        check("cnt0 busy", busy, 1'b0);
        @(posedge clock); #1;
        check("cnt0 done_single", done, 1'b0);

        // Reset while a byte is held: outputs clear at once and no done follows.
        dm_len = 512; dm_bp = 3; dm_crc = 0; dm_iface = 0; dm_silent = 0;
        b_hs = hs_cnt;
        @(posedge clock); #1;
        start = 1'b1; start_block = 32'h44; block_count = 8'd2;
        got = 0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (hs_cnt >= b_hs + 3 && out_valid) begin
                got = 1;
                break;
            end
        end
        check("hold_reached", got, 1'b1);
        check("hold_data", out_data, 8'h03);
        b_done = done_cnt;
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_outputs", outs(), 37'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        check("abort_no_done", done_cnt - b_done, 0);
        check("abort_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
